// File: rtl/esc_onewire_uart.sv
// Half-duplex single-wire 8N1 bridge: sends command bytes, holds the line high for a
// turnaround guard, releases the pin, then receives reply bytes on the same wire.
module esc_onewire_uart #(
  parameter int CLK_FREQ_HZ     = 72_000_000,
  parameter int BAUD            = 19200,
  parameter int TURNAROUND_BITS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy,
  input  logic       line_in,
  output logic       line_out,
  output logic       line_oe
);

  localparam int          BIT_CYCLES     = CLK_FREQ_HZ / BAUD;
  localparam logic [15:0] BIT_LAST       = 16'(BIT_CYCLES - 1);
  localparam logic [15:0] HALF_LAST      = 16'((BIT_CYCLES / 2) - 1);
  localparam logic [2:0]  HOLD_BITS_LAST = 3'(TURNAROUND_BITS - 1);

  typedef enum logic [2:0] {
    IDLE, TX_START, TX_DATA, TX_STOP, TX_HOLD, RX_START, RX_DATA, RX_STOP
  } state_t;

  state_t      state, state_d;
  logic [15:0] cnt, cnt_d;
  logic [2:0]  idx, idx_d;
  logic [7:0]  sh, sh_d;
  logic        sync_p0, sync_p1, prev, prev_d;
  logic        line_out_d, line_oe_d, tx_ready_d;
  logic        rx_valid_d, frame_err_d, busy_d;
  logic [7:0]  rx_data_d;
  logic        accept, fall, bit_end;

  always_comb begin
    state_d     = state;
    cnt_d       = cnt + 16'd1;
    idx_d       = idx;
    sh_d        = sh;
    prev_d      = sync_p1;
    line_out_d  = line_out;
    rx_data_d   = rx_data;
    rx_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    accept      = tx_valid && tx_ready;
    fall        = prev && !sync_p1;
    bit_end     = (cnt == BIT_LAST);

    case (state)
      IDLE: begin
        line_out_d = 1'b1;
        // A simultaneous byte and falling edge: the byte wins, the edge is dropped.
        if (accept) begin
          state_d    = TX_START;
          cnt_d      = 16'd0;
          sh_d       = tx_data;
          line_out_d = 1'b0;
        end else if (fall) begin
          state_d = RX_START;
          cnt_d   = 16'd0;
        end
      end
      TX_START: if (bit_end) begin
        state_d    = TX_DATA;
        cnt_d      = 16'd0;
        idx_d      = 3'd0;
        line_out_d = sh[0];
        sh_d       = {1'b0, sh[7:1]};
      end
      TX_DATA: if (bit_end) begin
        cnt_d = 16'd0;
        if (idx == 3'd7) begin
          state_d    = TX_STOP;
          line_out_d = 1'b1;
        end else begin
          idx_d      = idx + 3'd1;
          line_out_d = sh[0];
          sh_d       = {1'b0, sh[7:1]};
        end
      end
      TX_STOP: if (bit_end) begin
        state_d = TX_HOLD;
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
      end
      TX_HOLD: begin
        // Guard time is counted in whole bit times so the counter stays 16 bits wide.
        if (accept) begin
          state_d    = TX_START;
          cnt_d      = 16'd0;
          sh_d       = tx_data;
          line_out_d = 1'b0;
        end else if (bit_end) begin
          cnt_d = 16'd0;
          if (idx == HOLD_BITS_LAST) begin
            state_d = IDLE;
            prev_d  = 1'b1;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
      RX_START: if (cnt == HALF_LAST) begin
        cnt_d   = 16'd0;
        idx_d   = 3'd0;
        state_d = sync_p1 ? IDLE : RX_DATA;
      end
      RX_DATA: if (bit_end) begin
        cnt_d = 16'd0;
        sh_d  = {sync_p1, sh[7:1]};
        if (idx == 3'd7) state_d = RX_STOP;
        else             idx_d   = idx + 3'd1;
      end
      RX_STOP: if (bit_end) begin
        state_d = IDLE;
        if (sync_p1) begin
          rx_data_d  = sh;
          rx_valid_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!enable) begin
      state_d     = IDLE;
      line_out_d  = 1'b1;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
    end

    line_oe_d  = (state_d == TX_START) || (state_d == TX_DATA) ||
                 (state_d == TX_STOP)  || (state_d == TX_HOLD);
    tx_ready_d = enable && ((state_d == IDLE) || (state_d == TX_HOLD));
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      line_oe   <= 1'b0;
      line_out  <= 1'b1;
      tx_ready  <= 1'b0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      rx_data   <= 8'd0;
      busy      <= 1'b0;
      sync_p0   <= 1'b1;
      sync_p1   <= 1'b1;
      prev      <= 1'b1;
    end else begin
      state     <= state_d;
      line_oe   <= line_oe_d;
      line_out  <= line_out_d;
      tx_ready  <= tx_ready_d;
      rx_valid  <= rx_valid_d;
      frame_err <= frame_err_d;
      rx_data   <= rx_data_d;
      busy      <= busy_d;
      sync_p0   <= line_in;
      sync_p1   <= sync_p0;
      prev      <= prev_d;
    end
  end

  always_ff @(posedge clk) begin
    cnt <= cnt_d;
    idx <= idx_d;
    sh  <= sh_d;
  end

endmodule

// File: tb/tb_esc_onewire_uart.sv
// Directed bench for esc_onewire_uart at 10 clocks per bit: TX frames, back-to-back,
// turnaround release, RX good/bad frames, glitch rejection, echo immunity, abort paths.
module tb_esc_onewire_uart;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       line_in = 1'b1;
  logic       tx_ready, rx_valid, frame_err, busy, line_out, line_oe;
  logic [7:0] rx_data;

  int n_cmp = 0;
  int n_bad = 0;
  int n_rxv = 0;
  int n_fe  = 0;

  esc_onewire_uart #(
    .CLK_FREQ_HZ(1_000_000),
    .BAUD(100_000),
    .TURNAROUND_BITS(2)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err), .busy(busy),
    .line_in(line_in), .line_out(line_out), .line_oe(line_oe)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)  n_rxv <= n_rxv + 1;
    if (frame_err) n_fe  <= n_fe + 1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time exceeded, got timeout, required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [7:0] data;
    logic [0:9] pat;
  } tx_vec_t;

  typedef struct {
    logic [0:9] bits;
    logic [7:0] exp_valid;
    logic [7:0] exp_ferr;
    logic [7:0] exp_data;
  } rx_vec_t;

  tx_vec_t tx_tab[3];
  rx_vec_t rx_tab[4];

  task automatic check1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, required %b", name, act, exp);
    end
  endtask

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%02h, required 0x%02h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_byte(input string tag, input logic [7:0] d, input bit keep_valid);
    check1({tag, "_ready_before"}, tx_ready, 1'b1);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    if (!keep_valid) tx_valid = 1'b0;
    check1({tag, "_ready_after"}, tx_ready, 1'b0);
  endtask

  // Called at the first cycle of the start bit; returns at the first cycle after the stop bit.
  task automatic check_frame(input string tag, input logic [0:9] pat, input bit noisy);
    for (int b = 0; b < 10; b++) begin
      for (int k = 0; k < 10; k++) begin
        if (noisy) line_in = 1'($urandom);
        if (k == 0 || k == 9) begin
          check1($sformatf("%s_bit%0d_c%0d", tag, b, k), line_out, pat[b]);
          check1($sformatf("%s_oe%0d_c%0d", tag, b, k), line_oe, 1'b1);
        end
        tick();
      end
    end
    line_in = 1'b1;
  endtask

  task automatic hold_release(input string tag);
    check1({tag, "_hold_oe"}, line_oe, 1'b1);
    check1({tag, "_hold_out"}, line_out, 1'b1);
    check1({tag, "_hold_ready"}, tx_ready, 1'b1);
    repeat (19) tick();
    check1({tag, "_hold_oe_last"}, line_oe, 1'b1);
    tick();
    check1({tag, "_release_oe"}, line_oe, 1'b0);
    check1({tag, "_release_busy"}, busy, 1'b0);
  endtask

  task automatic drive_frame(input logic [0:9] bits);
    for (int b = 0; b < 10; b++) begin
      line_in = bits[b];
      repeat (10) tick();
    end
    line_in = 1'b1;
    repeat (15) tick();
  endtask

  int bv, bf;
  logic [0:9] pat30, pat01, patff;

  initial begin
    tx_tab[0] = '{data: 8'hA5, pat: 10'b0101001011};
    tx_tab[1] = '{data: 8'hFF, pat: 10'b0111111111};
    tx_tab[2] = '{data: 8'h01, pat: 10'b0100000001};
    pat30 = 10'b0000011001;
    pat01 = 10'b0100000001;
    patff = 10'b0111111111;

    rx_tab[0] = '{bits: 10'b0010110101, exp_valid: 8'd1, exp_ferr: 8'd0, exp_data: 8'h5A};
    rx_tab[1] = '{bits: 10'b0001111000, exp_valid: 8'd0, exp_ferr: 8'd1, exp_data: 8'h5A};
    rx_tab[2] = '{bits: 10'b0100000011, exp_valid: 8'd1, exp_ferr: 8'd0, exp_data: 8'h81};
    rx_tab[3] = '{bits: 10'b0000000000, exp_valid: 8'd0, exp_ferr: 8'd1, exp_data: 8'h81};

    repeat (3) tick();
    check1("rst_oe", line_oe, 1'b0);
    check1("rst_out", line_out, 1'b1);
    check1("rst_ready", tx_ready, 1'b0);
    check1("rst_rxv", rx_valid, 1'b0);
    check1("rst_ferr", frame_err, 1'b0);
    check8("rst_rxdata", rx_data, 8'h00);
    check1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();
    check1("post_rst_ready", tx_ready, 1'b1);
    repeat (2) tick();

    bv = n_rxv;
    bf = n_fe;
    for (int i = 0; i < 3; i++) begin
      send_byte($sformatf("tx%0d", i), tx_tab[i].data, 1'b0);
      check_frame($sformatf("tx%0d", i), tx_tab[i].pat, (i == 1));
      hold_release($sformatf("tx%0d", i));
      repeat (3) tick();
    end
    check8("echo_rxv", 8'(n_rxv - bv), 8'd0);
    check8("echo_ferr", 8'(n_fe - bf), 8'd0);

    send_byte("b2b0", 8'h30, 1'b1);
    tx_data = 8'h01;
    check_frame("b2b0", pat30, 1'b0);
    check1("b2b_hold_oe", line_oe, 1'b1);
    check1("b2b_hold_ready", tx_ready, 1'b1);
    tick();
    tx_valid = 1'b0;
    check_frame("b2b1", pat01, 1'b0);
    hold_release("b2b");
    repeat (3) tick();

    for (int i = 0; i < 4; i++) begin
      bv = n_rxv;
      bf = n_fe;
      drive_frame(rx_tab[i].bits);
      check8($sformatf("rx%0d_valid_cnt", i), 8'(n_rxv - bv), rx_tab[i].exp_valid);
      check8($sformatf("rx%0d_ferr_cnt", i), 8'(n_fe - bf), rx_tab[i].exp_ferr);
      check8($sformatf("rx%0d_data", i), rx_data, rx_tab[i].exp_data);
      check1($sformatf("rx%0d_busy", i), busy, 1'b0);
    end

    bv = n_rxv;
    bf = n_fe;
    line_in = 1'b0;
    repeat (3) tick();
    line_in = 1'b1;
    repeat (3) tick();
    check1("glitch_busy_mid", busy, 1'b1);
    repeat (10) tick();
    check1("glitch_busy_end", busy, 1'b0);
    check8("glitch_rxv", 8'(n_rxv - bv), 8'd0);
    check8("glitch_ferr", 8'(n_fe - bf), 8'd0);
    check8("glitch_data", rx_data, 8'h81);

    send_byte("en_abort", 8'hA5, 1'b0);
    repeat (52) tick();
    check1("en_mid_oe", line_oe, 1'b1);
    check1("en_mid_out", line_out, 1'b0);
    enable = 1'b0;
    tick();
    check1("en_off_oe", line_oe, 1'b0);
    check1("en_off_ready", tx_ready, 1'b0);
    check1("en_off_out", line_out, 1'b1);
    check1("en_off_busy", busy, 1'b0);
    enable = 1'b1;
    tick();
    send_byte("en_resend", 8'h01, 1'b0);
    check_frame("en_resend", pat01, 1'b0);
    hold_release("en_resend");
    repeat (3) tick();

    send_byte("rst_abort", 8'hA5, 1'b0);
    repeat (52) tick();
    check1("rstab_mid_oe", line_oe, 1'b1);
    rst = 1'b1;
    tick();
    check1("rstab_oe", line_oe, 1'b0);
    check1("rstab_ready", tx_ready, 1'b0);
    check1("rstab_busy", busy, 1'b0);
    check8("rstab_rxdata", rx_data, 8'h00);
    rst = 1'b0;
    tick();
    send_byte("rst_resend", 8'hFF, 1'b0);
    check_frame("rst_resend", patff, 1'b0);
    hold_release("rst_resend");
    check8("abort_rxv", 8'(n_rxv - bv), 8'd0);
    check8("abort_ferr", 8'(n_fe - bf), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
